// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared types and constants for the SD-card SPI-mode command sequencer.
package sd_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CMD,
    ST_POLL,
    ST_TRAIL,
    ST_DONE
  } state_t;

  localparam logic [1:0]  CMD_START_BITS     = 2'b01;
  localparam logic        CMD_STOP_BIT       = 1'b1;
  localparam logic [7:0]  FILL_BYTE          = 8'hFF;
  localparam int unsigned CMD_BYTES          = 6;
  localparam int unsigned FRAME_W            = 48;
  localparam int unsigned R1_IDLE_BIT        = 0;
  localparam int unsigned R1_ILLEGAL_CMD_BIT = 2;
  localparam int unsigned R1_START_BIT       = 7;

  // 48-bit command token, transmitted MSB-first
  function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0]  index,
                                                     input logic [31:0] arg,
                                                     input logic [6:0]  crc);
    return {CMD_START_BITS, index, arg, crc, CMD_STOP_BIT};
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_byte_issuer.sv
// Single-byte start / wait-for-new_data handshake with the SPI byte engine.
module sd_cmd_sequencer_byte_issuer
  import sd_cmd_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  input  logic       spi_busy_i,
  input  logic       spi_new_data_i,
  input  logic [7:0] spi_data_out_i,
  output logic       free_c_o,
  output logic       done_c_o,
  output logic [7:0] rx_c_o,
  output logic       spi_start_o,
  output logic [7:0] spi_data_in_o
);

  logic       inflight_q, inflight_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       fire;

  // new_data only counts when we own an outstanding byte; stale ones are dropped
  assign done_c_o = inflight_q & spi_new_data_i;
  assign free_c_o = ~inflight_q | spi_new_data_i;
  assign rx_c_o   = spi_data_out_i;

  assign spi_start_o   = start_q;
  assign spi_data_in_o = data_q;

  always_comb begin
    fire       = go_i & free_c_o & ~spi_busy_i;
    start_d    = fire;
    data_d     = fire ? byte_i : data_q;
    inflight_d = fire | (inflight_q & ~spi_new_data_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      start_q    <= 1'b0;
      data_q     <= FILL_BYTE;
    end else begin
      inflight_q <= inflight_d;
      start_q    <= start_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Frames SD SPI-mode commands (token, R1 polling, trailing clocks) onto spi_master.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned RESP_POLL_MAX = 8,
  parameter int unsigned INIT_BYTES    = 10,
  parameter int unsigned TRAIL_BYTES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_init,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        timeout,
  output logic        sd_cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  input  logic [7:0]  spi_data_out
);

  localparam logic [3:0] INIT_LAST  = 4'(INIT_BYTES);
  localparam logic [3:0] TRAIL_LAST = 4'(TRAIL_BYTES);
  localparam logic [3:0] CMD_LAST   = 4'(CMD_BYTES);
  localparam logic [7:0] POLL_LAST  = 8'(RESP_POLL_MAX);
  localparam state_t     AFTER_POLL = (TRAIL_BYTES == 0) ? ST_DONE : ST_TRAIL;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          poll_q, poll_d;
  logic [7:0]          r1_q, r1_d;
  logic                to_q, to_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                cs_n_q, cs_n_d;

  logic                go_c, free_c, done_c;
  logic [7:0]          byte_c, rx_c;

  sd_cmd_sequencer_byte_issuer u_issuer (
    .clk            (clk),
    .rst            (rst),
    .go_i           (go_c),
    .byte_i         (byte_c),
    .spi_busy_i     (spi_busy),
    .spi_new_data_i (spi_new_data),
    .spi_data_out_i (spi_data_out),
    .free_c_o       (free_c),
    .done_c_o       (done_c),
    .rx_c_o         (rx_c),
    .spi_start_o    (spi_start),
    .spi_data_in_o  (spi_data_in)
  );

  // Retire the completed byte first, then issue the next one from the new state
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    r1_d    = r1_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          sr_d    = build_frame(cmd_index, cmd_arg, cmd_crc);
          cnt_d   = '0;
          poll_d  = '0;
          r1_d    = FILL_BYTE;
          to_d    = 1'b0;
          state_d = cmd_init ? ST_INIT : ST_CMD;
        end
      end
      ST_INIT: begin
        if (done_c) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == INIT_LAST) state_d = ST_DONE;
        end
      end
      ST_CMD: begin
        if (done_c) begin
          cnt_d = cnt_q + 4'd1;
          sr_d  = {sr_q[FRAME_W-9:0], FILL_BYTE};
          if (cnt_d == CMD_LAST) begin
            cnt_d   = '0;
            state_d = ST_POLL;
          end
        end
      end
      ST_POLL: begin
        if (done_c) begin
          if (!rx_c[R1_START_BIT]) begin
            r1_d    = rx_c;
            cnt_d   = '0;
            state_d = AFTER_POLL;
          end else begin
            if (poll_q != 8'hFF) poll_d = poll_q + 8'd1;
            if (poll_d == POLL_LAST) begin
              to_d    = 1'b1;
              r1_d    = FILL_BYTE;
              cnt_d   = '0;
              state_d = AFTER_POLL;
            end
          end
        end
      end
      ST_TRAIL: begin
        if (done_c) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TRAIL_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    go_c    = (state_d inside {ST_INIT, ST_CMD, ST_POLL, ST_TRAIL}) && free_c;
    byte_c  = (state_d == ST_CMD) ? sr_d[FRAME_W-1 -: 8] : FILL_BYTE;
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
    cs_n_d  = !(state_d inside {ST_CMD, ST_POLL, ST_TRAIL});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      r1_q    <= FILL_BYTE;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      r1_q    <= r1_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_r1    = r1_q;
  assign timeout    = to_q;
  assign sd_cs_n    = cs_n_q;

endmodule
